// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V core types; fetch_entry_t is the fetch_queue storage record.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x fetch_entry_t storage, synchronous write, asynchronous read, not reset.
module fetch_queue_mem
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [AW-1:0] waddr_i,
    input  fetch_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fetch_entry_t rdata_o
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {instr, pc} buffer between fetch and decode with flush.
// FETCH_QUEUE_BYPASS_EN adds a zero-latency path from fetch to decode when the queue is empty.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_v_i,
    input  logic [31:0]              instr_i,
    input  logic [XLEN-1:0]          pc_i,
    output logic                     ready_o,
    input  logic                     flush_v_i,
    output logic                     instr_v_o,
    output logic [31:0]              instr_o,
    output logic [XLEN-1:0]          pc_o,
    input  logic                     dec_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count;
    logic          empty, full, byp, push, pop;
    fetch_entry_t  rd_data, head;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = count == '0;
    assign full  = count == PW'(DEPTH);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = empty & instr_v_i & ~flush_v_i & ~reset;
`else
    assign byp = 1'b0;
`endif

    // ready_o only looks at registered state, so a pop never frees a slot for the same cycle
    assign ready_o   = ~full & ~reset;
    assign instr_v_o = (~empty | byp) & ~flush_v_i & ~reset;
    assign push      = instr_v_i & ready_o & ~flush_v_i & ~(byp & dec_ready_i);
    assign pop       = instr_v_o & dec_ready_i & ~empty;
    assign head      = byp ? {instr_i, pc_i} : rd_data;
    assign instr_o   = instr_v_o ? head.instr : '0;
    assign pc_o      = instr_v_o ? head.pc : '0;
    assign count_o   = count;

    always_comb begin
        wr_ptr_d = reset ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = reset ? '0 : flush_v_i ? wr_ptr_q : rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
    end

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({instr_i, pc_i}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven stimulus with a cycle scoreboard model of the fetch queue.
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            instr_v_i = 1'b0;
    logic [31:0]     instr_i = '0;
    logic [XLEN-1:0] pc_i = '0;
    logic            ready_o;
    logic            flush_v_i = 1'b0;
    logic            instr_v_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic            dec_ready_i = 1'b0;
    logic [$clog2(DEPTH):0] count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_v_i   (instr_v_i),
        .instr_i     (instr_i),
        .pc_i        (pc_i),
        .ready_o     (ready_o),
        .flush_v_i   (flush_v_i),
        .instr_v_o   (instr_v_o),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .dec_ready_i (dec_ready_i),
        .count_o     (count_o)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h0000_0013 ^ {pc[11:0], 20'h0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: PCs expected to come out of decode, in order
    logic [31:0] sb[$];

    always @(negedge clk) begin
        int  mcnt;
        logic bp, exp_v, exp_rdy;
        logic [31:0] exp_pc;
        mcnt = sb.size();
        bp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bp = mcnt == 0 && instr_v_i && !flush_v_i && !reset;
`endif
        exp_v   = (mcnt > 0 || bp) && !flush_v_i && !reset;
        exp_rdy = mcnt < DEPTH && !reset;
        chk("ready_o", 64'(ready_o), 64'(exp_rdy));
        chk("instr_v_o", 64'(instr_v_o), 64'(exp_v));
        chk("count_o", 64'(count_o), 64'(mcnt));
        if (exp_v) begin
            exp_pc = bp ? pc_i : sb[0];
            chk("pc_o", 64'(pc_o), 64'(exp_pc));
            chk("instr_o", 64'(instr_o), 64'(instr_of(exp_pc)));
        end else begin
            chk("pc_o_idle", 64'(pc_o), 64'h0);
            chk("instr_o_idle", 64'(instr_o), 64'h0);
        end
        if (reset || flush_v_i) sb.delete();
        else if (bp) begin
            if (!dec_ready_i) sb.push_back(pc_i);
        end else begin
            if (exp_v && dec_ready_i) void'(sb.pop_front());
            if (instr_v_i && exp_rdy) sb.push_back(pc_i);
        end
    end

    typedef struct {
        logic        rst, v, fl, rdy;
        logic [31:0] pc;
        int          cnt, cnt_byp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, v, fl, rdy, input logic [31:0] pc, input int cnt, cnt_byp);
        vec_t e;
        e.rst = rst; e.v = v; e.fl = fl; e.rdy = rdy; e.pc = pc; e.cnt = cnt; e.cnt_byp = cnt_byp;
        vecs.push_back(e);
    endtask

    initial begin
        int exp_cnt;
        add(1, 0, 0, 0, 32'h0, 0, 0);
        add(0, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 32'h8000_0000 + 32'(4 * i), i < 4 ? i + 1 : 4, i < 4 ? i + 1 : 4);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 32'h0, 3 - i, 3 - i);
        add(0, 0, 0, 1, 32'h0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 0, 1, 32'h8000_0020 + 32'(4 * i), 1, 0);
        add(0, 0, 0, 1, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 32'h8000_0040 + 32'(4 * i), i + 1, i + 1);
        add(0, 1, 1, 1, 32'h8000_0100, 0, 0);
        add(0, 0, 0, 1, 32'h0, 0, 0);
        add(0, 1, 0, 0, 32'h8000_0050, 1, 1);
        add(0, 1, 0, 0, 32'h8000_0054, 2, 2);
        add(1, 1, 0, 1, 32'h8000_0060, 0, 0);
        add(0, 0, 0, 1, 32'h0, 0, 0);
        add(0, 1, 0, 0, 32'h8000_0070, 1, 1);
        add(0, 1, 0, 0, 32'h8000_0074, 2, 2);
        add(0, 1, 0, 1, 32'h8000_0078, 2, 2);
        add(0, 1, 0, 0, 32'h8000_007C, 3, 3);
        add(0, 1, 0, 0, 32'h8000_0080, 4, 4);
        add(0, 1, 0, 1, 32'h8000_0084, 3, 3);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 32'h0, 2 - i, 2 - i);
        add(0, 0, 0, 0, 32'h0, 0, 0);
        add(0, 1, 0, 1, 32'h8000_0200, 1, 0);
        add(0, 0, 0, 1, 32'h0, 0, 0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            instr_v_i = vecs[i].v;
            flush_v_i = vecs[i].fl;
            dec_ready_i = vecs[i].rdy;
            pc_i = vecs[i].pc;
            instr_i = instr_of(vecs[i].pc);
            @(posedge clk);
            #1;
            exp_cnt = vecs[i].cnt;
`ifdef FETCH_QUEUE_BYPASS_EN
            exp_cnt = vecs[i].cnt_byp;
`endif
            chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(exp_cnt));
        end

        // One-cycle push-to-output latency, checked right after the capturing edge
        reset = 1'b0; flush_v_i = 1'b0; instr_v_i = 1'b1; dec_ready_i = 1'b0;
        pc_i = 32'h8000_0300; instr_i = instr_of(pc_i);
        @(posedge clk);
        #1;
        instr_v_i = 1'b0;
        chk("lat_valid", 64'(instr_v_o), 64'h1);
        chk("lat_pc", 64'(pc_o), 64'h8000_0300);
        chk("lat_instr", 64'(instr_o), 64'(instr_of(32'h8000_0300)));
        dec_ready_i = 1'b1;
        @(posedge clk);
        #1;
        dec_ready_i = 1'b0;
        chk("lat_drained", 64'(instr_v_o), 64'h0);
        chk("lat_count", 64'(count_o), 64'h0);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and the decode stage. Captures one {instr, pc} pair per cycle from fetch into a DEPTH-entry circular FIFO and presents them in order to decode under a valid/ready handshake. It absorbs decode back-pressure without stalling the icache access, and drops all buffered work on an EXE flush.

## Interface
Parameters:
- DEPTH, 4: number of entries. Power of two, at least 2.
- XLEN: taken from riscv_pkg; not overridable.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- instr_v_i, input, 1: fetch offers an entry this cycle.
- instr_i, input, 32: fetched instruction.
- pc_i, input, XLEN: PC of instr_i.
- ready_o, output, 1: queue accepts a push this cycle.
- flush_v_i, input, 1: EXE redirect; discard all contents.
- instr_v_o, output, 1: head entry valid for decode.
- instr_o, output, 32: head instruction.
- pc_o, output, XLEN: head PC.
- dec_ready_i, input, 1: decode consumes the head this cycle.
- count_o, output, $clog2(DEPTH)+1: number of occupied entries.

## Operation
- State:
  - rd_ptr and wr_ptr, each $clog2(DEPTH)+1 bits, with a wrap bit.
  - Storage array of DEPTH {instr, pc} entries. Storage is not reset.
- Derived signals:
  - count = wr_ptr − rd_ptr (modulo 2^(ptr width)).
  - empty = (count == 0).
  - full = (count == DEPTH).
- Push = instr_v_i & ready_o & ~flush_v_i. Writes entry[wr_ptr] and increments wr_ptr.
- Pop = instr_v_o & dec_ready_i. Increments rd_ptr.
- ready_o = ~full & ~reset.
  - Depends only on registered state. There is no combinational path from dec_ready_i.
  - When full, a simultaneous pop does not enable a push in the same cycle.
- instr_v_o = ~empty & ~flush_v_i.
- instr_o and pc_o:
  - Show entry[rd_ptr] whenever instr_v_o=1.
  - Forced to 0 whenever instr_v_o=0.
- Simultaneous push and pop (not empty, not full): count is unchanged and both pointers advance.
- Pointer wrap: the index uses the low bits and the wrap bit toggles. DEPTH consecutive pushes from empty give full.
- Flush:
  - On the next edge rd_ptr ← wr_ptr, so the queue becomes empty.
  - A push offered in the flush cycle is discarded.
  - No pop occurs in the flush cycle, because instr_v_o is masked.
- Reset:
  - Pointers are set to 0, so count_o=0.
  - While reset is high: instr_v_o=0, instr_o=0, pc_o=0, ready_o=0.
  - If reset is asserted mid-operation, all contents are lost with no partial drain.

## Timing
- Push-to-output latency is one cycle. An entry pushed at edge N is visible on instr_o after edge N.
- Throughput: one push and one pop per cycle sustained.
- count_o is registered-state based and updates on the edge after a push or pop.
- First cycle after reset deasserts: ready_o=1, instr_v_o=0.

## Configuration
Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When empty & instr_v_i & ~flush_v_i, then instr_v_o=1, instr_o=instr_i and pc_o=pc_i, combinationally.
  - If dec_ready_i is also 1, the entry is consumed directly and is not written (pointers unchanged).
  - Otherwise it is written as a normal push.
  - Latency is zero when empty.
- Undefined: no bypass path. Latency is always one cycle, as above.

## Structure
- riscv_pkg gains typedef fetch_entry_t packed struct {logic [31:0] instr; logic [XLEN-1:0] pc;}. The storage array is declared as fetch_entry_t.
- The DEPTH assertion (power of two, at least 2) lives in the module as an elaboration-time check.
- One sub-module, fetch_queue_mem:
  - Holds DEPTH × fetch_entry_t.
  - One synchronous write port and one asynchronous read port.
- Pointer and handshake logic stays in fetch_queue.

## Test plan
- Reset then fill: push 0x00000013 at pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C with dec_ready_i=0 → count_o=4, ready_o=0 after the fourth edge; a fifth push is ignored.
- Drain in order: from the full state, set dec_ready_i=1 → pc_o sequence 0x80000000, 0x80000004, 0x80000008, 0x8000000C on consecutive cycles; then instr_v_o=0 and pc_o=0.
- Streaming wrap: ten back-to-back pushes with dec_ready_i=1 → count_o stays 1 in steady state (no bypass); every PC is delivered exactly once and in order across the pointer wrap.
- Flush with pending push: count_o=3, assert flush_v_i with instr_v_i=1 (pc 0x80000100) → instr_v_o=0 that cycle; count_o=0 next cycle; pc 0x80000100 is never delivered.
- Mid-operation reset: count_o=2, assert reset for one cycle → ready_o=0 and instr_v_o=0 during reset; count_o=0 afterwards; no stale entry is output.
- Bypass (FETCH_QUEUE_BYPASS_EN defined): empty queue, push pc 0x80000200 with dec_ready_i=1 → instr_v_o=1, pc_o=0x80000200 in the same cycle; count_o remains 0.
